fifo_drain_ctrl: RTL

Read-side controller for the team's `fifo` block: the consumer end of the push/pop interface that the bench currently drives from tasks. It issues `pop` against `empty`, absorbs the FIFO's 1-cycle read latency, and presents words on a valid/ready stream through a 2-entry skid buffer. It supports burst-length or continuous draining with stop/done/error handling.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_drain_ctrl_if.sv | 25 ++
 rtl/fifo_skid_buf2.sv | 66 ++++++
 rtl/fifo_drain_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word width, counter width and the drain-controller state type.
package fifo_pkg;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: FIFO read side plus the valid/ready output stream.
// master = drain controller, slave = FIFO / downstream consumer side.
interface fifo_drain_ctrl_if #(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH
);

  logic             fifo_empty;
  logic             fifo_error;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_pop;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  fifo_empty, fifo_error, fifo_data_out, m_ready,
    output fifo_pop, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_error, fifo_data_out, m_ready,
    input  fifo_pop, m_data, m_valid
  );

endinterface

// File: rtl/fifo_skid_buf2.sv
// fifo_skid_buf2: 2-entry in-order valid/ready buffer with registered outputs.
// The writer guarantees it never pushes into a full buffer without a same-cycle pop.
module fifo_skid_buf2 #(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             accept_c;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign occ       = cnt_q;
  assign accept_c  = out_valid & out_ready;

  // Next-state: write behind the head, shift tail forward on accept.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({in_valid, accept_c})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops the team fifo, absorbs its 1-cycle read latency and
// streams words out through a 2-entry skid buffer; burst or continuous drain.
// Optional FIFO_DRAIN_STATS_EN adds a saturating stall_cnt output.
module fifo_drain_ctrl #(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH,
  parameter int unsigned LEN_W = fifo_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] burst_len,
  fifo_drain_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [LEN_W-1:0] popped_cnt
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  import fifo_pkg::*;

  drain_state_t     state_q, state_d;
  logic [LEN_W-1:0] burst_len_q, burst_len_d;
  logic [LEN_W-1:0] popped_q, popped_d;
  logic             inflight_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       buf_occ;
  logic [2:0]       occ_c;
  logic             accept_c;
  logic             burst_hit_c;
  logic             pop_c;

  // Occupancy counts the word in flight from the fifo as already owned.
  assign accept_c    = bus.m_valid & bus.m_ready;
  assign occ_c       = 3'(buf_occ) + 3'(inflight_q);
  assign burst_hit_c = (burst_len_q != '0) && (popped_q == burst_len_q);
  assign pop_c       = (state_q == RUN) & ~bus.fifo_empty & ~bus.fifo_error &
                       (occ_c < (3'd2 + 3'(accept_c))) & ~burst_hit_c;
  assign bus.fifo_pop = pop_c;

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_flag   = err_q;
  assign popped_cnt = popped_q;

  // Word returned by the fifo one cycle after the pop lands in the skid buffer.
  fifo_skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (bus.fifo_data_out),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (bus.m_data),
    .occ       (buf_occ)
  );

  // Next-state and registered-output logic; error beats stop beats burst end.
  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    popped_d    = popped_q;
    err_d       = err_q;
    done_d      = 1'b0;
    if (pop_c) popped_d = popped_q + LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          burst_len_d = burst_len;
          popped_d    = '0;
          err_d       = 1'b0;
        end
      end
      RUN: begin
        if (bus.fifo_error) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (stop) begin
          state_d = DRAIN;
        end else if (burst_hit_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_c == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ERR: begin
        if (occ_c == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  // State, counters and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_len_q <= '0;
      popped_q    <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
      popped_q    <= popped_d;
      inflight_q  <= pop_c;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where the consumer holds off a valid word.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (bus.m_valid && !bus.m_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
